module_multiword_adder_ctrl: RTL and testbench

- Sequencer that performs NUM_WORDS*WORD_WIDTH-bit add/subtract by time-multiplexing one WORD_WIDTH-bit carry look-ahead adder.
- Processes one word per cycle, least-significant word first, and chains the carry through a register.
- Sits between a requester with valid/ready handshake and the shared adder datapath.
- Used where a full-width CLA is too large.

---
 rtl/multiword_adder_pkg.sv | 11 +
 rtl/module_carry_look_ahead_adder.sv | 45 ++++
 rtl/module_multiword_adder_ctrl.sv | 134 +++++++++++++
 tb/tb_module_multiword_adder_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/multiword_adder_pkg.sv
// Shared types for the multi-word add/subtract sequencer.
// No logic here: state encoding and operation codes only.
// Imported by the sequencer top.
package multiword_adder_pkg;

    typedef enum logic [1:0] {IDLE, ADD, DONE} mwa_state_e;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/module_carry_look_ahead_adder.sv
// Single CLA_WIDTH-bit carry look-ahead adder slice.
// Latency: purely combinational.
// Backpressure: none, no handshake.
module module_carry_look_ahead_adder #(
    parameter int CLA_WIDTH = 32
) (
    input  logic [CLA_WIDTH-1:0] a_i,
    input  logic [CLA_WIDTH-1:0] b_i,
    input  logic                 carry_i,
    output logic [CLA_WIDTH-1:0] sum_o,
    output logic                 carry_o
);

    logic [CLA_WIDTH-1:0] g;
    logic [CLA_WIDTH-1:0] p;
    logic [CLA_WIDTH:0]   c;

    assign g = a_i & b_i;
    assign p = a_i ^ b_i;

    // Each carry is the flattened sum-of-products over all lower generate terms,
    // so no carry depends on another computed carry.
    always_comb begin
        logic acc;
        logic pp;
        acc = 1'b0;
        pp  = 1'b0;
        c   = '0;
        c[0] = carry_i;
        for (int i = 0; i < CLA_WIDTH; i++) begin
            acc = g[i];
            pp  = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                acc = acc | (pp & g[j]);
                pp  = pp & p[j];
            end
            acc      = acc | (pp & carry_i);
            c[i + 1] = acc;
        end
    end

    assign sum_o   = p ^ c[CLA_WIDTH-1:0];
    assign carry_o = c[CLA_WIDTH];

endmodule

// File: rtl/module_multiword_adder_ctrl.sv
// Wide add/subtract by time-multiplexing one WORD_WIDTH CLA slice, LS word first.
// Latency: accept at edge T0, valid_o high after edge T0+NUM_WORDS.
// Backpressure: result held in DONE until ready_i; no accept until back in IDLE.
module module_multiword_adder_ctrl
    import multiword_adder_pkg::*;
#(
    parameter int WORD_WIDTH = 32,
    parameter int NUM_WORDS  = 4
) (
    input  logic                              clk_i,
    input  logic                              rst_n_i,
    input  logic                              valid_i,
    output logic                              ready_o,
    input  logic                              sub_i,
    input  logic                              carry_i,
    input  logic [NUM_WORDS*WORD_WIDTH-1:0]   a_i,
    input  logic [NUM_WORDS*WORD_WIDTH-1:0]   b_i,
    output logic                              valid_o,
    input  logic                              ready_i,
    output logic [NUM_WORDS*WORD_WIDTH-1:0]   sum_o,
    output logic                              carry_o,
    output logic                              overflow_o,
    output logic                              busy_o
);

    localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    mwa_state_e                              state;
    logic [IDX_W-1:0]                        idx;
    logic [NUM_WORDS-1:0][WORD_WIDTH-1:0]    a_reg;
    logic [NUM_WORDS-1:0][WORD_WIDTH-1:0]    b_reg;
    logic [NUM_WORDS-1:0][WORD_WIDTH-1:0]    sum_reg;
    logic [NUM_WORDS-1:0][WORD_WIDTH-1:0]    result;
    logic                                    carry_reg;
    logic [WORD_WIDTH-1:0]                   slice_a;
    logic [WORD_WIDTH-1:0]                   slice_b;
    logic [WORD_WIDTH-1:0]                   slice_sum;
    logic                                    slice_co;
    logic                                    last;
    logic                                    slice_ovf;

    always_comb begin
        slice_a = '0;
        slice_b = '0;
        for (int w = 0; w < NUM_WORDS; w++) begin
            if (idx == IDX_W'(w)) begin
                slice_a = a_reg[w];
                slice_b = b_reg[w];
            end
        end
    end

    module_carry_look_ahead_adder #(.CLA_WIDTH(WORD_WIDTH)) u_slice (
        .a_i     (slice_a),
        .b_i     (slice_b),
        .carry_i (carry_reg),
        .sum_o   (slice_sum),
        .carry_o (slice_co)
    );

    assign last = (idx == IDX_W'(NUM_WORDS - 1));

    // b_reg already holds ~B for subtract, so this is the plain add-overflow rule.
    assign slice_ovf = (a_reg[NUM_WORDS-1][WORD_WIDTH-1] == b_reg[NUM_WORDS-1][WORD_WIDTH-1]) &&
                       (slice_sum[WORD_WIDTH-1] != a_reg[NUM_WORDS-1][WORD_WIDTH-1]);

    always_comb begin
        result = sum_reg;
        result[NUM_WORDS-1] = slice_sum;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state      <= IDLE;
            idx        <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            sum_reg    <= '0;
            carry_reg  <= 1'b0;
            ready_o    <= 1'b1;
            valid_o    <= 1'b0;
            busy_o     <= 1'b0;
            sum_o      <= '0;
            carry_o    <= 1'b0;
            overflow_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (valid_i && ready_o) begin
                        a_reg     <= a_i;
                        b_reg     <= (sub_i == OP_ADD) ? b_i : ~b_i;
                        carry_reg <= (sub_i == OP_SUB) ? 1'b1 : carry_i;
                        idx       <= '0;
                        ready_o   <= 1'b0;
                        busy_o    <= 1'b1;
                        state     <= ADD;
                    end
                end
                ADD: begin
                    for (int w = 0; w < NUM_WORDS; w++) begin
                        if (idx == IDX_W'(w)) begin
                            sum_reg[w] <= slice_sum;
                        end
                    end
                    carry_reg <= slice_co;
                    if (last) begin
                        sum_o      <= result;
                        carry_o    <= slice_co;
                        overflow_o <= slice_ovf;
                        busy_o     <= 1'b0;
                        valid_o    <= 1'b1;
                        state      <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (ready_i) begin
                        valid_o <= 1'b0;
                        ready_o <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    ready_o <= 1'b1;
                    valid_o <= 1'b0;
                    busy_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_module_multiword_adder_ctrl.sv
// Bench for the multi-word adder sequencer: 4x8 and 1x8 instances, directed plus random.
// Expected results come from plain wide arithmetic in ref_op.
module tb_module_multiword_adder_ctrl;

    logic clk;
    logic rst_n;

    logic        valid4, sub4, cin4, rdy_i4;
    logic [31:0] a4, b4;
    logic        ready_o4, valid_o4, co4, ov4, busy4;
    logic [31:0] sum4;

    logic        valid1, sub1, cin1, rdy_i1;
    logic [7:0]  a1, b1;
    logic        ready_o1, valid_o1, co1, ov1, busy1;
    logic [7:0]  sum1;

    int total  = 0;
    int passed = 0;

    module_multiword_adder_ctrl #(.WORD_WIDTH(8), .NUM_WORDS(4)) dut4 (
        .clk_i(clk), .rst_n_i(rst_n), .valid_i(valid4), .ready_o(ready_o4),
        .sub_i(sub4), .carry_i(cin4), .a_i(a4), .b_i(b4),
        .valid_o(valid_o4), .ready_i(rdy_i4), .sum_o(sum4),
        .carry_o(co4), .overflow_o(ov4), .busy_o(busy4)
    );

    module_multiword_adder_ctrl #(.WORD_WIDTH(8), .NUM_WORDS(1)) dut1 (
        .clk_i(clk), .rst_n_i(rst_n), .valid_i(valid1), .ready_o(ready_o1),
        .sub_i(sub1), .carry_i(cin1), .a_i(a1), .b_i(b1),
        .valid_o(valid_o1), .ready_i(rdy_i1), .sum_o(sum1),
        .carry_o(co1), .overflow_o(ov1), .busy_o(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 1000000");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // n-bit unsigned/two's-complement reference using 64-bit integers.
    function automatic void ref_op(input longint unsigned a, input longint unsigned b,
                                   input bit sub, input bit cin, input int n,
                                   output longint unsigned sum, output bit c, output bit ov);
        longint unsigned mask;
        longint unsigned full;
        longint sa, sb, r, lim;
        mask = (64'd1 << n) - 64'd1;
        lim  = longint'(1) << (n - 1);
        sa   = a[n-1] ? longint'(a) - (longint'(1) << n) : longint'(a);
        sb   = b[n-1] ? longint'(b) - (longint'(1) << n) : longint'(b);
        if (sub) begin
            sum = (a - b) & mask;
            c   = (a >= b);
            r   = sa - sb;
        end else begin
            full = a + b + longint'(cin);
            sum  = full & mask;
            c    = (full >> n) != 0;
            r    = sa + sb + longint'(cin);
        end
        ov = (r >= lim) || (r < -lim);
    endfunction

    task automatic run4(input logic [31:0] a, input logic [31:0] b, input logic sub, input logic cin,
                        input logic [31:0] es, input logic ec, input logic eo, input bit release_res,
                        input string tag);
        int lat;
        chk({tag, ".ready_before"}, ready_o4, 1);
        a4 = a; b4 = b; sub4 = sub; cin4 = cin; valid4 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid4 = 1'b0; a4 = $urandom; b4 = $urandom; sub4 = ~sub; cin4 = ~cin;
        chk({tag, ".busy"}, {busy4, ready_o4}, 2'b10);
        lat = 0;
        while (valid_o4 !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, ".latency"}, lat, 4);
        chk({tag, ".sum"}, sum4, es);
        chk({tag, ".carry_ovf"}, {co4, ov4}, {ec, eo});
        if (release_res) begin
            rdy_i4 = 1'b1;
            @(posedge clk);
            @(negedge clk);
            rdy_i4 = 1'b0;
            chk({tag, ".after_hs"}, {ready_o4, valid_o4, busy4}, 3'b100);
            chk({tag, ".sum_held"}, sum4, es);
        end
    endtask

    task automatic run1(input logic [7:0] a, input logic [7:0] b, input logic sub, input logic cin,
                        input logic [7:0] es, input logic ec, input logic eo, input string tag);
        int lat;
        chk({tag, ".ready_before"}, ready_o1, 1);
        a1 = a; b1 = b; sub1 = sub; cin1 = cin; valid1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid1 = 1'b0; a1 = 8'($urandom); b1 = 8'($urandom);
        chk({tag, ".busy"}, {busy1, ready_o1, valid_o1}, 3'b100);
        lat = 0;
        while (valid_o1 !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, ".latency"}, lat, 1);
        chk({tag, ".result"}, {sum1, co1, ov1}, {es, ec, eo});
        rdy_i1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rdy_i1 = 1'b0;
        chk({tag, ".after_hs"}, {ready_o1, valid_o1}, 2'b10);
    endtask

    initial begin
        longint unsigned rs;
        bit rc, ro, rsub, rcin;
        logic [31:0] ra, rb;

        rst_n = 1'b0;
        valid4 = 0; sub4 = 0; cin4 = 0; rdy_i4 = 0; a4 = 0; b4 = 0;
        valid1 = 0; sub1 = 0; cin1 = 0; rdy_i1 = 0; a1 = 0; b1 = 0;
        repeat (3) @(negedge clk);
        chk("reset4", {ready_o4, valid_o4, busy4, sum4, co4, ov4}, {3'b100, 32'h0, 2'b00});
        chk("reset1", {ready_o1, valid_o1, busy1, sum1, co1, ov1}, {3'b100, 8'h0, 2'b00});
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset4", {ready_o4, valid_o4, busy4}, 3'b100);

        run4(32'h00FFFFFF, 32'h00000001, 0, 0, 32'h01000000, 0, 0, 1, "ripple");
        run4(32'hFFFFFFFF, 32'h00000001, 0, 0, 32'h00000000, 1, 0, 1, "ucarry");
        run4(32'h7FFFFFFF, 32'h00000001, 0, 0, 32'h80000000, 0, 1, 1, "sovf");
        run4(32'h00000005, 32'h00000007, 1, 1, 32'hFFFFFFFE, 0, 0, 1, "sub_borrow");
        run4(32'h80000000, 32'h00000001, 1, 0, 32'h7FFFFFFF, 1, 1, 1, "sub_ovf");
        run4(32'h12340000, 32'h00005678, 0, 1, 32'h12345679, 0, 0, 1, "carry_in");

        run4(32'h00000011, 32'h00000022, 0, 0, 32'h00000033, 0, 0, 0, "bp");
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin valid4 = 1'b1; a4 = 32'hAA; b4 = 32'h55; end
            if (i == 4) valid4 = 1'b0;
            @(negedge clk);
            chk("bp.hold", {valid_o4, ready_o4, busy4, sum4}, {3'b100, 32'h33});
        end
        rdy_i4 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rdy_i4 = 1'b0;
        chk("bp.release", {ready_o4, valid_o4, busy4}, 3'b100);
        @(negedge clk);
        chk("bp.no_late_accept", {ready_o4, busy4}, 2'b10);

        a4 = 32'h12345678; b4 = 32'h11111111; sub4 = 0; cin4 = 1; valid4 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid4 = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1 chk("midop_reset", {ready_o4, valid_o4, busy4, sum4, co4, ov4}, {3'b100, 32'h0, 2'b00});
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run4(32'h00000001, 32'h00000002, 0, 0, 32'h00000003, 0, 0, 1, "after_abort");

        run1(8'hF0, 8'h20, 0, 0, 8'h10, 1, 0, "n1_dir");

        for (int i = 0; i < 150; i++) begin
            ra = $urandom; rb = $urandom;
            if (i % 5 == 0) rb = ~ra;
            if (i % 7 == 0) ra = 32'h80000000;
            rsub = 1'($urandom_range(0, 1));
            rcin = 1'($urandom_range(0, 1));
            ref_op(64'(ra), 64'(rb), rsub, rcin, 32, rs, rc, ro);
            run4(ra, rb, rsub, rcin, rs[31:0], rc, ro, 1, "rand4");
        end

        for (int i = 0; i < 1000; i++) begin
            ra = 32'($urandom_range(0, 255));
            rb = 32'($urandom_range(0, 255));
            rsub = 1'($urandom_range(0, 1));
            rcin = 1'($urandom_range(0, 1));
            ref_op(64'(ra), 64'(rb), rsub, rcin, 8, rs, rc, ro);
            run1(ra[7:0], rb[7:0], rsub, rcin, rs[7:0], rc, ro, "rand1");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
